rst_seq: RTL and testbench

RST_SEQ -- requirements
Module: rst_seq

---
 rtl/rst_seq_pkg.sv | 22 ++
 rtl/rst_seq_sync_debounce.sv | 41 ++++
 rtl/rst_seq.sv | 139 +++++++++++++
 tb/tb_rst_seq.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// Shared types and constants for the rst_seq reset sequencer.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT,
    ST_WAIT_LOCK,
    ST_REL_PERIPH,
    ST_RUN
  } state_t;

  localparam logic [2:0] CAUSE_POR  = 3'd0;
  localparam logic [2:0] CAUSE_BTN  = 3'd1;
  localparam logic [2:0] CAUSE_EXT  = 3'd2;
  localparam logic [2:0] CAUSE_SOFT = 3'd3;
  localparam logic [2:0] CAUSE_LOCK = 3'd4;
  localparam logic [2:0] CAUSE_TRAP = 3'd5;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rst_seq_sync_debounce.sv
// Two-flop synchronizer followed by a debouncer: the output follows the
// synchronized input only after it has differed for DEB_CYCLES consecutive cycles.
module sync_debounce #(
  parameter int   DEB_CYCLES = 16,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_async,
  output logic o_level
);

  localparam int             CW   = $clog2(DEB_CYCLES) + 1;
  localparam logic [CW-1:0]  LAST = CW'(DEB_CYCLES - 1);

  logic [1:0]    sync_ff;
  logic [CW-1:0] cnt;
  logic          sync_level;

  assign sync_level = sync_ff[1];

  // NOTE: non-blocking assignments keep sync_ff a true two-stage shift chain.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sync_ff <= '0;
      cnt     <= '0;
      o_level <= IDLE_LEVEL;
    end else begin
      sync_ff <= {sync_ff[0], i_async};
      if (sync_level == o_level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        o_level <= sync_level;
        cnt     <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/rst_seq.sv
// Power-on / button / external / soft / lock-loss reset sequencer.
// Define RST_SEQ_TRAP_RESET_EN to make a CPU trap in RUN a reset trigger.
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int DEB_CYCLES  = 16,
  parameter int HOLD_CYCLES = 1024,
  parameter int GAP_CYCLES  = 16
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_pll_locked,
  input  logic       i_btn_n,
  input  logic       i_ext_reset_n,
  input  logic       i_soft_req,
  input  logic       i_trap,
  output logic       o_periph_reset,
  output logic       o_cpu_reset,
  output logic       o_busy,
  output logic [2:0] o_cause
);

  localparam int               CNT_W     = $clog2(max_int(HOLD_CYCLES, GAP_CYCLES)) + 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       cause, cause_n;
  logic [1:0]       lock_ff;
  logic             lock_sync;
  logic             btn_level, ext_level;
  logic             btn_act, ext_act;
  logic             trap_trig;
  logic             trig;
  logic [2:0]       trig_cause;

  sync_debounce #(.DEB_CYCLES(DEB_CYCLES), .IDLE_LEVEL(1'b1)) u_btn_deb (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_async (i_btn_n),
    .o_level (btn_level)
  );

  sync_debounce #(.DEB_CYCLES(DEB_CYCLES), .IDLE_LEVEL(1'b1)) u_ext_deb (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_async (i_ext_reset_n),
    .o_level (ext_level)
  );

  assign btn_act   = ~btn_level;
  assign ext_act   = ~ext_level;
  assign lock_sync = lock_ff[1];

`ifdef RST_SEQ_TRAP_RESET_EN
  assign trap_trig = i_trap && (state == ST_RUN);
`else
  logic unused_trap;
  assign unused_trap = i_trap;
  assign trap_trig   = 1'b0;
`endif

  // Trigger arbitration: earlier branches win when several fire together.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no latch is inferred.
    trig       = 1'b0;
    trig_cause = cause;
    if (!lock_sync && (state == ST_REL_PERIPH || state == ST_RUN)) begin
      trig       = 1'b1;
      trig_cause = CAUSE_LOCK;
    end else if (ext_act && state != ST_ASSERT) begin
      trig       = 1'b1;
      trig_cause = CAUSE_EXT;
    end else if (btn_act && state != ST_ASSERT) begin
      trig       = 1'b1;
      trig_cause = CAUSE_BTN;
    end else if (trap_trig) begin
      trig       = 1'b1;
      trig_cause = CAUSE_TRAP;
    end else if (i_soft_req && state == ST_RUN) begin
      trig       = 1'b1;
      trig_cause = CAUSE_SOFT;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cause_n = cause;
    case (state)
      ST_ASSERT: begin
        if (cnt >= HOLD_LAST && !btn_act && !ext_act) begin
          state_n = ST_WAIT_LOCK;
          cnt_n   = '0;
        end else if (cnt < HOLD_LAST) begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      ST_WAIT_LOCK: begin
        if (lock_sync) begin
          state_n = ST_REL_PERIPH;
          cnt_n   = '0;
        end
      end
      ST_REL_PERIPH: begin
        if (cnt >= GAP_LAST) state_n = ST_RUN;
        else                 cnt_n   = cnt + CNT_W'(1);
      end
      ST_RUN:  ;
      default: state_n = ST_ASSERT;
    endcase
    if (trig) begin
      state_n = ST_ASSERT;
      cnt_n   = '0;
      cause_n = trig_cause;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state   <= ST_ASSERT;
      cnt     <= '0;
      cause   <= CAUSE_POR;
      lock_ff <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      cause   <= cause_n;
      lock_ff <= {lock_ff[0], i_pll_locked};
    end
  end

  assign o_periph_reset = (state == ST_ASSERT) || (state == ST_WAIT_LOCK);
  assign o_cpu_reset    = (state != ST_RUN);
  assign o_busy         = (state != ST_RUN);
  assign o_cause        = cause;

endmodule

// File: tb/tb_rst_seq.sv
// Randomized self-checking bench for rst_seq; expected release times are
// computed from the sequencing rules as edge arithmetic.
module tb_rst_seq;

  localparam int DEB  = 4;
  localparam int HOLD = 8;
  localparam int GAP  = 4;
  localparam int SYNC = 2;

  logic       i_clk = 1'b0;
  logic       i_reset, i_pll_locked, i_btn_n, i_ext_reset_n, i_soft_req, i_trap;
  logic       o_periph_reset, o_cpu_reset, o_busy;
  logic [2:0] o_cause;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;
  int last_cause = 0;
  int btn_up_at, ext_up_at, lock_up_at, soft_on_at, soft_off_at, trap_off_at;

  rst_seq #(.DEB_CYCLES(DEB), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP)) dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_pll_locked   (i_pll_locked),
    .i_btn_n        (i_btn_n),
    .i_ext_reset_n  (i_ext_reset_n),
    .i_soft_req     (i_soft_req),
    .i_trap         (i_trap),
    .o_periph_reset (o_periph_reset),
    .o_cpu_reset    (o_cpu_reset),
    .o_busy         (o_busy),
    .o_cause        (o_cause)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic clear_sched();
    btn_up_at = -1; ext_up_at = -1; lock_up_at = -1;
    soft_on_at = -1; soft_off_at = -1; trap_off_at = -1;
  endtask

  task automatic apply_sched();
    if (cyc == btn_up_at)   i_btn_n       = 1'b1;
    if (cyc == ext_up_at)   i_ext_reset_n = 1'b1;
    if (cyc == lock_up_at)  i_pll_locked  = 1'b1;
    if (cyc == soft_on_at)  i_soft_req    = 1'b1;
    if (cyc == soft_off_at) i_soft_req    = 1'b0;
    if (cyc == trap_off_at) i_trap        = 1'b0;
  endtask

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Edge after which the peripheral reset is low, given the edge the hold
  // started, the edge the last debounced trigger went inactive, and the edge
  // the synchronized lock became 1 (0 = not a constraint).
  function automatic int exp_rel(input int trig, input int deb_clear, input int lock_ok);
    int wl;
    wl = imax(trig + HOLD, deb_clear + 1);
    return imax(wl, lock_ok) + 1;
  endfunction

  task automatic run_seq(input string tag, input int exp_assert, input int exp_cause,
                         input int trig, input int deb_clear, input int lock_ok);
    int assert_at, periph_at, cpu_at, cause_a, cpu_held, busy_seen, exp_p;
    assert_at = -1; periph_at = -1; cpu_at = -1; cause_a = -1; cpu_held = -1;
    exp_p = exp_rel(trig, deb_clear, lock_ok);
    for (int i = 0; i < 400; i++) begin
      step(1);
      apply_sched();
      if (assert_at < 0) begin
        if (o_periph_reset && o_cpu_reset) begin
          assert_at = cyc;
          cause_a   = int'(o_cause);
        end
      end else if (periph_at < 0) begin
        if (!o_periph_reset) begin
          periph_at = cyc;
          cpu_held  = int'(o_cpu_reset);
        end
      end else if (!o_cpu_reset) begin
        cpu_at = cyc;
        break;
      end
    end
    check({tag, "_assert_edge"}, assert_at, exp_assert);
    check({tag, "_cause_at_assert"}, cause_a, exp_cause);
    check({tag, "_periph_release_edge"}, periph_at, exp_p);
    check({tag, "_cpu_held_at_periph_release"}, cpu_held, 1);
    check({tag, "_cpu_release_edge"}, cpu_at, exp_p + GAP);
    busy_seen = 0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      busy_seen |= int'(o_busy);
    end
    check({tag, "_busy_idle_after_run"}, busy_seen, 0);
    check({tag, "_cause_final"}, int'(o_cause), exp_cause);
    last_cause = exp_cause;
    clear_sched();
  endtask

  task automatic glitch(input string tag, input bit use_ext);
    int g, busy_seen;
    g = int'($urandom_range(1, DEB - 1));
    busy_seen = 0;
    if (use_ext) i_ext_reset_n = 1'b0; else i_btn_n = 1'b0;
    for (int i = 0; i < g + DEB + 8; i++) begin
      step(1);
      if (i == g - 1) begin
        i_ext_reset_n = 1'b1;
        i_btn_n       = 1'b1;
      end
      busy_seen |= int'(o_busy);
    end
    check({tag, "_busy"}, busy_seen, 0);
    check({tag, "_cause"}, int'(o_cause), last_cause);
  endtask

  // Press button and/or external reset for the given cycle counts; a soft
  // request is pulsed while in ASSERT and must be dropped.
  task automatic press(input string tag, input bit use_btn, input bit use_ext,
                       input int h_btn, input int h_ext, input int exp_cause);
    int p, assert_e, clr;
    p = cyc;
    clr = 0;
    if (use_btn) begin
      i_btn_n = 1'b0;
      btn_up_at = p + h_btn;
      clr = imax(clr, p + h_btn + SYNC + DEB);
    end
    if (use_ext) begin
      i_ext_reset_n = 1'b0;
      ext_up_at = p + h_ext;
      clr = imax(clr, p + h_ext + SYNC + DEB);
    end
    assert_e    = p + SYNC + DEB + 1;
    soft_on_at  = assert_e + 2;
    soft_off_at = assert_e + 3;
    run_seq(tag, assert_e, exp_cause, assert_e, clr, 0);
  endtask

  initial begin
    int s, n, j, k, r, busy_seen, hb, he, pick;
    clear_sched();
    i_reset = 1'b1; i_pll_locked = 1'b1; i_btn_n = 1'b1; i_ext_reset_n = 1'b1;
    i_soft_req = 1'b0; i_trap = 1'b0;

    // Reset state while i_reset is held.
    step(1);
    check("rst_periph", int'(o_periph_reset), 1);
    check("rst_cpu", int'(o_cpu_reset), 1);
    check("rst_busy", int'(o_busy), 1);
    check("rst_cause", int'(o_cause), 0);
    step(1);
    i_reset = 1'b0;
    run_seq("por", 3, 0, 2, 0, 0);

    // Soft reset from RUN.
    step(int'($urandom_range(2, 6)));
    s = cyc;
    i_soft_req  = 1'b1;
    soft_off_at = s + 1;
    run_seq("soft", s + 1, 3, s + 1, 0, 0);

    glitch("btn_glitch", 1'b0);
    glitch("ext_glitch", 1'b1);

    press("btn_hold20", 1'b1, 1'b0, 20, 0, 1);

    for (int it = 0; it < 3; it++) begin
      step(int'($urandom_range(2, 8)));
      hb = int'($urandom_range(6, 25));
      he = int'($urandom_range(6, 25));
      pick = int'($urandom_range(0, 2));
      if (pick == 0)      press("rand_btn", 1'b1, 1'b0, hb, 0, 1);
      else if (pick == 1) press("rand_ext", 1'b0, 1'b1, 0, he, 2);
      else                press("rand_both", 1'b1, 1'b1, hb, he, 2);
    end

    // Soft request and synchronized lock loss in the same RUN cycle.
    step(int'($urandom_range(2, 6)));
    n = cyc;
    i_pll_locked = 1'b0;
    soft_on_at   = n + SYNC;
    soft_off_at  = n + SYNC + 1;
    lock_up_at   = n + SYNC + 1 + HOLD + int'($urandom_range(3, 12));
    run_seq("lock_soft", n + 3, 4, n + 3, 0, lock_up_at + SYNC);

    // One-cycle lock drop while the peripheral reset is already released.
    step(int'($urandom_range(2, 6)));
    s = cyc;
    i_soft_req = 1'b1;
    step(1);
    i_soft_req = 1'b0;
    step(HOLD + 1);
    check("rel_periph_low", int'(o_periph_reset), 0);
    check("rel_cpu_high", int'(o_cpu_reset), 1);
    j = int'($urandom_range(0, GAP - 3));
    if (j > 0) step(j);
    n = cyc;
    i_pll_locked = 1'b0;
    step(1);
    i_pll_locked = 1'b1;
    run_seq("lock_rel", n + 3, 4, n + 3, 0, n + 3);

    // Trap in RUN.
    step(int'($urandom_range(2, 6)));
`ifdef RST_SEQ_TRAP_RESET_EN
    s = cyc;
    i_trap      = 1'b1;
    trap_off_at = s + 1;
    run_seq("trap", s + 1, 5, s + 1, 0, 0);
`else
    i_trap = 1'b1;
    busy_seen = 0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      busy_seen |= int'(o_busy);
    end
    i_trap = 1'b0;
    check("trap_ignored_busy", busy_seen, 0);
    check("trap_ignored_cause", int'(o_cause), last_cause);
`endif

    // i_reset in the middle of a sequence restarts from scratch.
    step(int'($urandom_range(2, 6)));
    i_soft_req = 1'b1;
    step(1);
    i_soft_req = 1'b0;
    k = int'($urandom_range(2, HOLD + GAP));
    step(k);
    i_reset = 1'b1;
    step(1);
    check("midrst_cause", int'(o_cause), 0);
    check("midrst_periph", int'(o_periph_reset), 1);
    i_reset = 1'b0;
    r = cyc;
    run_seq("midrst", r + 1, 0, r, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
